// File: rtl/mlp_frame_sequencer.sv
// mlp_frame_sequencer
// Front-end sequencer for the combinational printed-MLP core `top`.
// Serial features arrive over a valid/ready stream and are packed into the
// core's flat input bus. Once a well-formed frame is complete the bus is held
// for a fixed settle window, then the core's class output is captured and
// offered on a valid/ready result port. Frames never overlap: a new frame is
// only accepted after the previous result has been taken.
`timescale 1ns/1ps

module mlp_frame_sequencer #(
    parameter int unsigned NUM_A         = 4,
    parameter int unsigned WIDTH_A       = 4,
    parameter int unsigned OUTWIDTH      = 2,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    // feature stream
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH_A-1:0]         s_data,
    input  logic                       s_last,
    // MLP core interface
    output logic [NUM_A*WIDTH_A-1:0]   mlp_inp,
    input  logic [OUTWIDTH-1:0]        mlp_out,
    // result stream
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [OUTWIDTH-1:0]        m_class,
    // status
    output logic                       busy,
    output logic                       frame_err
);

    localparam int unsigned IW = $clog2(NUM_A + 1);
    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_A - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SETTLE  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t                     state;
    logic [IW-1:0]              idx;
    logic [CW-1:0]              cnt;
    logic [NUM_A*WIDTH_A-1:0]   feat;
    logic                       accept;

    // The feature registers drive the core directly; they only change on an
    // accepted beat, so the core input is stable through SETTLE and PRESENT.
    assign mlp_inp = feat;

    // Beats are only taken while collecting, and never while reset is held.
    assign s_ready = rst_n && (state == COLLECT);
    assign accept  = s_valid && s_ready;

    // Status is a pure decode of the state register.
    assign busy    = (state != COLLECT);

    // Sequencer FSM: frame collection, settle timing, result hand-off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= COLLECT;
            idx       <= '0;
            cnt       <= '0;
            feat      <= '0;
            m_class   <= '0;
            m_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        // Store the beat in the slot selected by idx; a
                        // malformed frame leaves partial data that the next
                        // frame simply overwrites.
                        for (int unsigned i = 0; i < NUM_A; i++) begin
                            if (idx == IW'(i)) begin
                                feat[i*WIDTH_A +: WIDTH_A] <= s_data;
                            end
                        end
                        if (idx == IDX_LAST) begin
                            idx <= '0;
                            if (s_last) begin
                                cnt   <= '0;
                                state <= SETTLE;
                            end else begin
                                // last slot filled but no end marker
                                frame_err <= 1'b1;
                            end
                        end else if (s_last) begin
                            // end marker arrived before the frame was full
                            idx       <= '0;
                            frame_err <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

                SETTLE: begin
                    // The core output is only looked at on the final settle
                    // edge; anything it does before then is ignored.
                    if (cnt == CNT_LAST) begin
                        m_class <= mlp_out;
                        m_valid <= 1'b1;
                        state   <= PRESENT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                PRESENT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= COLLECT;
                    end
                end

                default: begin
                    state   <= COLLECT;
                    m_valid <= 1'b0;
                    idx     <= '0;
                end
            endcase
        end
    end

endmodule
